reg_file_mp: RTL and testbench

//  Parametrised multi-port register file: DEPTH entries of WIDTH bits, two independent

---
 rtl/reg_file_mp.sv | 133 +++++++++++++
 tb/tb_reg_file_mp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: two registered read ports, byte-masked write, bulk load, clear.
// Reads return data one cycle after the request. Define REG_FILE_MP_BYPASS_EN for write-first collisions.
module reg_file_mp #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [$clog2(DEPTH)-1:0] r_a_raddr_in,
   input  logic                     r_a_ren_in,
   input  logic [$clog2(DEPTH)-1:0] r_b_raddr_in,
   input  logic                     r_b_ren_in,
   input  logic [$clog2(DEPTH)-1:0] w_addr_in,
   input  logic                     w_en_in,
   input  logic [WIDTH/8-1:0]       w_be_in,
   input  logic [WIDTH-1:0]         w_data_in,
   input  logic                     bulk_en_in,
   input  logic [DEPTH*WIDTH-1:0]   bulk_in,
   input  logic                     clear_in,
   output logic [WIDTH-1:0]         a_out,
   output logic                     a_valid_out,
   output logic [WIDTH-1:0]         b_out,
   output logic                     b_valid_out,
   output logic [7:0]               wr_count_out
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int NBYTES = WIDTH / 8;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem     [DEPTH];
   logic [WIDTH-1:0] mem_nxt [DEPTH];

   logic w_addr_ok;
   logic a_addr_ok;
   logic b_addr_ok;
   logic single_wr;
   logic wr_accepted;
   logic [WIDTH-1:0] a_rd_data;
   logic [WIDTH-1:0] b_rd_data;

   // Addresses at or beyond DEPTH only exist when DEPTH is not a power of two.
   assign w_addr_ok = ({1'b0, w_addr_in} < DEPTH_L);
   assign a_addr_ok = ({1'b0, r_a_raddr_in} < DEPTH_L);
   assign b_addr_ok = ({1'b0, r_b_raddr_in} < DEPTH_L);

   assign single_wr   = w_en_in && (|w_be_in) && w_addr_ok;
   assign wr_accepted = !clear_in && (bulk_en_in || single_wr);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_nxt[i] = mem[i];
         if (clear_in) begin
            mem_nxt[i] = '0;
         end else if (bulk_en_in) begin
            mem_nxt[i] = bulk_in[WIDTH*i +: WIDTH];
         end else if (single_wr && (w_addr_in == ADDR_W'(i))) begin
            for (int k = 0; k < NBYTES; k++) begin
               if (w_be_in[k]) begin
                  mem_nxt[i][8*k +: 8] = w_data_in[8*k +: 8];
               end
            end
         end
      end
   end

`ifdef REG_FILE_MP_BYPASS_EN
   // Write-first: a read colliding with any write sees the post-write contents.
   always_comb begin
      a_rd_data = '0;
      b_rd_data = '0;
      if (a_addr_ok) begin
         a_rd_data = mem_nxt[r_a_raddr_in];
      end
      if (b_addr_ok) begin
         b_rd_data = mem_nxt[r_b_raddr_in];
      end
   end
`else
   // Read-first: a read colliding with any write sees the pre-write contents.
   always_comb begin
      a_rd_data = '0;
      b_rd_data = '0;
      if (a_addr_ok) begin
         a_rd_data = mem[r_a_raddr_in];
      end
      if (b_addr_ok) begin
         b_rd_data = mem[r_b_raddr_in];
      end
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= mem_nxt[i];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_out       <= '0;
         a_valid_out <= 1'b0;
         b_out       <= '0;
         b_valid_out <= 1'b0;
      end else begin
         a_valid_out <= r_a_ren_in;
         b_valid_out <= r_b_ren_in;
         if (r_a_ren_in) begin
            a_out <= a_rd_data;
         end
         if (r_b_ren_in) begin
            b_out <= b_rd_data;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_count_out <= '0;
      end else if (clear_in) begin
         wr_count_out <= '0;
      end else if (wr_accepted && (wr_count_out != 8'hFF)) begin
         wr_count_out <= wr_count_out + 8'd1;
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized bench for reg_file_mp (WIDTH=16, DEPTH=4) against an array-based reference model.
module tb_reg_file_mp;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
`ifdef REG_FILE_MP_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  r_a_raddr_in = '0;
   logic        r_a_ren_in = 1'b0;
   logic [1:0]  r_b_raddr_in = '0;
   logic        r_b_ren_in = 1'b0;
   logic [1:0]  w_addr_in = '0;
   logic        w_en_in = 1'b0;
   logic [1:0]  w_be_in = '0;
   logic [15:0] w_data_in = '0;
   logic        bulk_en_in = 1'b0;
   logic [63:0] bulk_in = '0;
   logic        clear_in = 1'b0;
   logic [15:0] a_out;
   logic        a_valid_out;
   logic [15:0] b_out;
   logic        b_valid_out;
   logic [7:0]  wr_count_out;

   reg_file_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n),
      .r_a_raddr_in(r_a_raddr_in), .r_a_ren_in(r_a_ren_in),
      .r_b_raddr_in(r_b_raddr_in), .r_b_ren_in(r_b_ren_in),
      .w_addr_in(w_addr_in), .w_en_in(w_en_in), .w_be_in(w_be_in), .w_data_in(w_data_in),
      .bulk_en_in(bulk_en_in), .bulk_in(bulk_in), .clear_in(clear_in),
      .a_out(a_out), .a_valid_out(a_valid_out),
      .b_out(b_out), .b_valid_out(b_valid_out),
      .wr_count_out(wr_count_out)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail = 0;

   int          m_mem [DEPTH];
   int          m_cnt;
   int          e_a, e_b;
   bit          e_av, e_bv;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
      m_cnt = 0;
      e_a = 0; e_b = 0; e_av = 0; e_bv = 0;
   endtask

   task automatic idle();
      r_a_ren_in = 0; r_b_ren_in = 0; w_en_in = 0; w_be_in = 0;
      bulk_en_in = 0; clear_in = 0;
   endtask

   // Apply the current inputs for one clock edge, update the model, compare all outputs.
   task automatic step();
      int nxt [DEPTH];
      int mask;
      for (int i = 0; i < DEPTH; i++) nxt[i] = m_mem[i];
      if (clear_in) begin
         for (int i = 0; i < DEPTH; i++) nxt[i] = 0;
         m_cnt = 0;
      end else if (bulk_en_in) begin
         for (int i = 0; i < DEPTH; i++) nxt[i] = int'(bulk_in >> (16 * i)) & 32'hFFFF;
         if (m_cnt < 255) m_cnt++;
      end else if (w_en_in && w_be_in != 0) begin
         mask = (w_be_in[0] ? 32'h00FF : 0) + (w_be_in[1] ? 32'hFF00 : 0);
         nxt[w_addr_in] = (m_mem[w_addr_in] & ~mask) | (int'(w_data_in) & mask);
         if (m_cnt < 255) m_cnt++;
      end
      e_av = r_a_ren_in;
      e_bv = r_b_ren_in;
      if (r_a_ren_in) e_a = BYP ? nxt[r_a_raddr_in] : m_mem[r_a_raddr_in];
      if (r_b_ren_in) e_b = BYP ? nxt[r_b_raddr_in] : m_mem[r_b_raddr_in];
      for (int i = 0; i < DEPTH; i++) m_mem[i] = nxt[i];
      @(posedge clock);
      #1;
      check("a_valid", 32'(a_valid_out), 32'(e_av));
      check("a_out", 32'(a_out), e_a);
      check("b_valid", 32'(b_valid_out), 32'(e_bv));
      check("b_out", 32'(b_out), e_b);
      check("wr_count", 32'(wr_count_out), m_cnt);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("reset_a_out", 32'(a_out), 0);
      check("reset_a_valid", 32'(a_valid_out), 0);
      check("reset_b_valid", 32'(b_valid_out), 0);
      check("reset_count", 32'(wr_count_out), 0);
      reset_n = 1;

      for (int i = 0; i < DEPTH; i++) begin
         idle();
         r_a_ren_in = 1; r_a_raddr_in = 2'(i);
         r_b_ren_in = 1; r_b_raddr_in = 2'(3 - i);
         step();
         check("reset_read", 32'(a_out), 0);
      end

      idle();
      bulk_en_in = 1; bulk_in = 64'h4444_3333_2222_1111;
      step();
      idle();
      r_a_ren_in = 1; r_a_raddr_in = 2; r_b_ren_in = 1; r_b_raddr_in = 0;
      step();
      check("bulk_a_addr2", 32'(a_out), 32'h3333);
      check("bulk_b_addr0", 32'(b_out), 32'h1111);
      check("bulk_count", 32'(wr_count_out), 1);

      idle();
      w_en_in = 1; w_addr_in = 1; w_be_in = 2'b01; w_data_in = 16'hABCD;
      step();
      idle();
      r_a_ren_in = 1; r_a_raddr_in = 1;
      step();
      check("byte_merge", 32'(a_out), 32'h22CD);
      idle();
      w_en_in = 1; w_addr_in = 1; w_be_in = 2'b00; w_data_in = 16'hFFFF;
      step();
      idle();
      r_b_ren_in = 1; r_b_raddr_in = 1;
      step();
      check("be_zero_noop", 32'(b_out), 32'h22CD);
      check("be_zero_count", 32'(wr_count_out), 2);

      idle();
      w_en_in = 1; w_addr_in = 3; w_be_in = 2'b11; w_data_in = 16'h5555;
      r_a_ren_in = 1; r_a_raddr_in = 3;
      step();
      check("collision", 32'(a_out), BYP ? 32'h5555 : 32'h4444);

      idle();
      clear_in = 1; bulk_en_in = 1; bulk_in = 64'hFFFF_FFFF_FFFF_FFFF;
      w_en_in = 1; w_be_in = 2'b11; w_addr_in = 0; w_data_in = 16'h1234;
      step();
      check("clear_count", 32'(wr_count_out), 0);
      for (int i = 0; i < DEPTH; i++) begin
         idle();
         r_a_ren_in = 1; r_a_raddr_in = 2'(i);
         step();
         check("clear_entry", 32'(a_out), 0);
      end

      for (int n = 0; n < 600; n++) begin
         idle();
         clear_in     = ($urandom_range(0, 31) == 0);
         bulk_en_in   = ($urandom_range(0, 7) == 0);
         bulk_in      = {$urandom, $urandom};
         w_en_in      = $urandom_range(0, 1);
         w_be_in      = 2'($urandom);
         w_addr_in    = 2'($urandom);
         w_data_in    = 16'($urandom);
         r_a_ren_in   = $urandom_range(0, 1);
         r_a_raddr_in = 2'($urandom);
         r_b_ren_in   = $urandom_range(0, 1);
         r_b_raddr_in = 2'($urandom);
         step();
      end

      for (int n = 0; n < 300; n++) begin
         idle();
         w_en_in = 1; w_be_in = 2'($urandom_range(1, 3));
         w_addr_in = 2'($urandom); w_data_in = 16'($urandom);
         r_b_ren_in = $urandom_range(0, 1); r_b_raddr_in = 2'($urandom);
         step();
      end
      check("saturate", 32'(wr_count_out), 255);

      idle();
      r_a_ren_in = 1; r_a_raddr_in = 2'($urandom);
      step();
      #2;
      reset_n = 0;
      #1;
      model_reset();
      check("rst_mid_a_valid", 32'(a_valid_out), 0);
      check("rst_mid_a_out", 32'(a_out), 0);
      check("rst_mid_count", 32'(wr_count_out), 0);
      @(posedge clock);
      #1;
      reset_n = 1;
      idle();
      r_a_ren_in = 1; r_a_raddr_in = 1; r_b_ren_in = 1; r_b_raddr_in = 2;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
